toplama_unit: RTL and testbench

//   Multi-cycle 32-bit two's-complement adder with a level "ready" handshake and no start strobe.
//   It recomputes automatically whenever its operand inputs differ from the operands it last captured.
//   It is the arithmetic core under the calculator's add/subtract paths. The subtract wrapper feeds
//   it sayi1 and (~sayi2 + 1), then waits for hazir before capturing sonuc/gecerli/tasma.

---
 rtl/toplama_pkg.sv | 20 ++
 rtl/toplama_slice.sv | 14 +
 rtl/toplama_unit.sv | 96 +++++++++
 tb/tb_toplama_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/toplama_pkg.sv
// Shared constants and types for the multi-cycle sliced adder.
package toplama_pkg;

  localparam int TOPLAMA_WIDTH   = 32;
  localparam int TOPLAMA_SLICE_W = 8;
  localparam int NUM_SLICES      = TOPLAMA_WIDTH / TOPLAMA_SLICE_W;

  // Keeps the counter at least one bit wide when a single slice covers the word.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = cnt_width(NUM_SLICES);

  typedef enum logic {
    ADD  = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage

// File: rtl/toplama_slice.sv
// Combinational SLICE_W-bit ripple slice: {cout, s} = a + b + cin.
module toplama_slice #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/toplama_unit.sv
// Multi-cycle two's-complement adder, one slice per clock, recomputes whenever operands change.
// state | meaning:  ADD = adding slice[cnt] each clock  |  DONE = result held until reload
module toplama_unit
  import toplama_pkg::*;
#(
  parameter int WIDTH   = TOPLAMA_WIDTH,
  parameter int SLICE_W = TOPLAMA_SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sayi1,
  input  logic [WIDTH-1:0] sayi2,
  output logic [WIDTH-1:0] sonuc,
  output logic             hazir,
  output logic             gecerli,
  output logic             tasma
);

  localparam int                N_SL     = WIDTH / SLICE_W;
  localparam int                CW       = cnt_width(N_SL);
  localparam logic [CW-1:0]     LAST_CNT = CW'(N_SL - 1);

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   psum;
  logic [WIDTH-1:0]   full_sum;
  logic [CW-1:0]      cnt;
  logic               carry;
  logic               done;
  state_t             state;

  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] s_sl;
  logic               c_out;
  logic               reload;
  logic               ovf;

  assign reload = ({sayi1, sayi2} != {op_a, op_b});
  assign a_sl   = op_a[int'(cnt)*SLICE_W +: SLICE_W];
  assign b_sl   = op_b[int'(cnt)*SLICE_W +: SLICE_W];

  toplama_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry),
    .s    (s_sl),
    .cout (c_out)
  );

  // Partial sum with the current slice merged in; on the last slice this is the full result.
  always_comb begin
    full_sum = psum;
    full_sum[int'(cnt)*SLICE_W +: SLICE_W] = s_sl;
  end

  assign ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (full_sum[WIDTH-1] != op_a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      psum    <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      done    <= 1'b0;
      state   <= ADD;
      sonuc   <= '0;
      gecerli <= 1'b0;
      tasma   <= 1'b0;
    end else if (reload) begin
      op_a  <= sayi1;
      op_b  <= sayi2;
      cnt   <= '0;
      carry <= 1'b0;
      done  <= 1'b0;
      state <= ADD;
    end else if (state == ADD) begin
      psum  <= full_sum;
      carry <= c_out;
      if (cnt == LAST_CNT) begin
        sonuc   <= full_sum;
        tasma   <= ovf;
        gecerli <= ~ovf;
        done    <= 1'b1;
        state   <= DONE;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Combinational so a wrapper never sees hazir high against operands it did not compute.
  assign hazir = done && (sayi1 == op_a) && (sayi2 == op_b);

endmodule

// File: tb/tb_toplama_unit.sv
// Self-checking bench for toplama_unit: scoreboard of expected results, one task per scenario.
module tb_toplama_unit;

  localparam int LIMIT = 20;

  typedef struct packed {
    logic [31:0] s;
    logic        g;
    logic        t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sayi1;
  logic [31:0] sayi2;
  logic [31:0] sonuc;
  logic        hazir;
  logic        gecerli;
  logic        tasma;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t last_exp;

  toplama_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sayi1   (sayi1),
    .sayi2   (sayi2),
    .sonuc   (sonuc),
    .hazir   (hazir),
    .gecerli (gecerli),
    .tasma   (tasma)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] sum;
    logic        ov;
    sum = a + b;
    ov  = (a[31] == b[31]) && (sum[31] != a[31]);
    e.s = sum;
    e.g = ~ov;
    e.t = ov;
    return e;
  endfunction

  // Inputs change just after a negedge, well away from the sampling posedge.
  task automatic apply(input logic [31:0] a, input logic [31:0] b);
    sayi1 = a;
    sayi2 = b;
    sb.push_back(model(a, b));
  endtask

  task automatic wait_hazir(output int edges);
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (!hazir && edges < LIMIT);
  endtask

  task automatic pop_exp(output exp_t e, output logic ok);
    ok = (sb.size() != 0);
    if (ok) e = sb.pop_front();
    else    e = '0;
  endtask

  task automatic test_reset();
    int   n;
    exp_t e;
    logic ok;
    rst_n = 1'b0;
    sayi1 = '0;
    sayi2 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sonuc, gecerli, tasma, hazir} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got sonuc=%h g=%b t=%b hazir=%b, need all 0", sonuc, gecerli, tasma, hazir);
    end
    rst_n = 1'b1;
    sb.push_back(model(32'd0, 32'd0));
    wait_hazir(n);
    checks++;
    if (!hazir || n != 4) begin
      errors++;
      $display("FAIL reset_latency: hazir=%b after %0d edges, need 1 after 4", hazir, n);
    end
    pop_exp(e, ok);
    checks++;
    if (!ok || {sonuc, gecerli, tasma} !== e) begin
      errors++;
      $display("FAIL reset_result: got %h/%b/%b, need %h/%b/%b", sonuc, gecerli, tasma, e.s, e.g, e.t);
    end
    last_exp = e;
  endtask

  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b);
    int   n;
    exp_t e;
    logic ok;
    apply(a, b);
    #1;
    checks++;
    if (hazir !== 1'b0) begin
      errors++;
      $display("FAIL %s_drop: hazir=%b right after input change, need 0", name, hazir);
    end
    wait_hazir(n);
    checks++;
    if (!hazir || n != 5) begin
      errors++;
      $display("FAIL %s_latency: hazir=%b after %0d edges, need 1 after 5", name, hazir, n);
    end
    pop_exp(e, ok);
    checks++;
    if (!ok || {sonuc, gecerli, tasma} !== e) begin
      errors++;
      $display("FAIL %s_result: got %h/%b/%b, need %h/%b/%b", name, sonuc, gecerli, tasma, e.s, e.g, e.t);
    end
    last_exp = e;
  endtask

  task automatic test_basic();
    run_one("basic", 32'd5, 32'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (hazir !== 1'b1 || sonuc !== 32'd12) begin
        errors++;
        $display("FAIL basic_hold: cycle %0d hazir=%b sonuc=%h, need 1 and 0000000c", i, hazir, sonuc);
      end
    end
  endtask

  task automatic test_overflow();
    run_one("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001);
    run_one("ovf_neg", 32'h8000_0000, 32'h8000_0000);
  endtask

  task automatic test_carry_out();
    run_one("carry_only", 32'hFFFF_FFFF, 32'h0000_0001);
    run_one("subtract", 32'd10, 32'hFFFF_FFFD);
  endtask

  task automatic test_mid_change();
    int   n;
    exp_t e;
    logic ok;
    logic bad;
    exp_t old;
    old   = last_exp;
    sayi1 = 32'd1;
    sayi2 = 32'd2;
    bad   = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (hazir !== 1'b0 || {sonuc, gecerli, tasma} !== old) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midchg_abandon: hazir=%b sonuc=%h during 1+2, need 0 and %h", hazir, sonuc, old.s);
    end
    apply(32'd100, 32'd200);
    n   = 0;
    bad = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (!hazir && {sonuc, gecerli, tasma} !== old) bad = 1'b1;
    end while (!hazir && n < LIMIT);
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midchg_hold: sonuc=%h changed before hazir, need %h", sonuc, old.s);
    end
    checks++;
    if (!hazir || n != 5) begin
      errors++;
      $display("FAIL midchg_latency: hazir=%b after %0d edges, need 1 after 5", hazir, n);
    end
    pop_exp(e, ok);
    checks++;
    if (!ok || {sonuc, gecerli, tasma} !== e) begin
      errors++;
      $display("FAIL midchg_result: got %h/%b/%b, need %h/%b/%b", sonuc, gecerli, tasma, e.s, e.g, e.t);
    end
    last_exp = e;
  endtask

  task automatic test_reset_mid();
    int   n;
    exp_t e;
    logic ok;
    apply(32'd3, 32'd4);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({sonuc, gecerli, tasma, hazir} !== 35'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got sonuc=%h g=%b t=%b hazir=%b, need all 0", sonuc, gecerli, tasma, hazir);
    end
    rst_n = 1'b1;
    wait_hazir(n);
    checks++;
    if (!hazir || n != 5) begin
      errors++;
      $display("FAIL rstmid_latency: hazir=%b after %0d edges, need 1 after 5", hazir, n);
    end
    pop_exp(e, ok);
    checks++;
    if (!ok || {sonuc, gecerli, tasma} !== e) begin
      errors++;
      $display("FAIL rstmid_result: got %h/%b/%b, need %h/%b/%b", sonuc, gecerli, tasma, e.s, e.g, e.t);
    end
    last_exp = e;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 0) b = 32'h8000_0000 - a;
      run_one($sformatf("b2b%0d", i), a, b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_carry_out();
    test_mid_change();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, need 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
